// File: rtl/axis_mux_pkg.sv
// Shared constants and state type for the N:1 AXI-Stream multiplexer.
package axis_mux_pkg;

  // Arbitration modes selectable through the MODE parameter.
  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // IDLE arbitrates, PKT forwards beats from the locked channel.
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_e;

endpackage

// File: rtl/axis_mux_n_if.sv
// Bundle of the N slave streams plus the single master stream of the mux.
// The slave modport is the multiplexer's view; master is the environment's view.
interface axis_mux_n_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
);
  logic [N*DATA_W-1:0] s_data;
  logic [N-1:0]        s_valid;
  logic [N-1:0]        s_ready;
  logic [N-1:0]        s_last;
  logic [DATA_W-1:0]   m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/axis_out_reg.sv
// One-stage data/last/valid output register with ready back-pressure.
// The caller may only assert load while can_load is high.
module axis_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              can_load,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  // A new beat fits when the register is empty or is being drained this cycle.
  assign can_load  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

  // Load a new beat, otherwise drop valid once the consumer has taken the held one.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = in_data;
      last_d  = in_last;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output state; reset empties the stage immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/axis_mux_n.sv
// N:1 AXI-Stream multiplexer with packet locking. Arbitration happens only in
// IDLE (explicit select or round-robin); the locked channel is held until the
// beat carrying s_last is accepted. Output passes through axis_out_reg.
module axis_mux_n
  import axis_mux_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  N      = 4,
  parameter int  MODE   = MODE_SEL,
  localparam int SEL_W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  axis_mux_n_if.slave      bus,
  output logic [SEL_W-1:0] grant,
  output logic             busy
);
  // Valid vector widened to every sel code so out-of-range selects read as 0.
  localparam int NP = 1 << SEL_W;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;
  logic [SEL_W-1:0]  rr_pick, rr_idx;
  logic              rr_found;
  logic [NP-1:0]     valid_ext;
  logic [N-1:0]      ready_c;
  logic [DATA_W-1:0] beat_data;
  logic              accept, can_load;

  assign valid_ext   = NP'(bus.s_valid);
  assign bus.s_ready = ready_c;
  assign grant       = grant_q;
  assign busy        = (state_q == PKT);

  // Round-robin search starting just after the previously granted channel.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      rr_idx = SEL_W'((int'(last_grant_q) + k) % N);
      if (!rr_found && bus.s_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // N:1 data selection driven by the locked channel.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == SEL_W'(i)) beat_data = bus.s_data[i*DATA_W +: DATA_W];
    end
  end

  // Arbitration in IDLE, beat forwarding and packet-end detection in PKT.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ready_c      = '0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (MODE == MODE_RR) begin
          if (rr_found) begin
            grant_d      = rr_pick;
            last_grant_d = rr_pick;
            state_d      = PKT;
          end
        end else if (valid_ext[sel]) begin
          grant_d = sel;
          state_d = PKT;
        end
      end
      PKT: begin
        ready_c[grant_q] = can_load;
        accept           = bus.s_valid[grant_q] && can_load;
        if (accept && bus.s_last[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lock state; last_grant starts at N-1 so channel 0 is first in round-robin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_W'(N - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  axis_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .in_data  (beat_data),
    .in_last  (bus.s_last[grant_q]),
    .out_ready(bus.m_ready),
    .can_load (can_load),
    .out_data (bus.m_data),
    .out_valid(bus.m_valid),
    .out_last (bus.m_last)
  );
endmodule

// File: doc/axis_mux_n.md
# axis_mux_n

Parametrised N:1 AXI-Stream multiplexer with packet-level locking, selectable arbitration mode and a registered output stage. It sits between multiple AXI-Stream producers and a single consumer. It generalises the 2:1 stream mux to any channel count and data width. It never switches input channel mid-packet, and it adds a round-robin mode alongside the explicit-select mode.

## Interface
- DATA_W, 8, data width per channel in bits
- N, 4, number of slave channels (2..16)
- MODE, 0, 0 = explicit select via `sel`; 1 = round-robin among valid channels
- SEL_W, $clog2(N), width of `sel`/`grant` (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-high reset
- sel  in  SEL_W  channel select; used only when MODE=0 and sampled only in IDLE
- s_data  in  N*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- s_valid  in  N  per-channel valid
- s_ready  out  N  per-channel ready
- s_last  in  N  per-channel end-of-packet
- m_data  out  DATA_W  output data (registered)
- m_valid  out  1  output valid (registered)
- m_ready  in  1  downstream ready
- m_last  out  1  output end-of-packet (registered)
- grant  out  SEL_W  index of the currently locked channel
- busy  out  1  high while in PKT state

## Operation
- FSM states: IDLE, PKT.
- IDLE arbitration:
  - MODE=0: if s_valid[sel] is high, register grant=sel and go to PKT. Otherwise stay in IDLE.
  - MODE=1: starting from (last_grant+1) mod N, choose the first i with s_valid[i] high. Register grant=i, update last_grant=i, go to PKT. If no channel is valid, stay in IDLE.
- In IDLE, all s_ready = 0. No beat is accepted in the arbitration cycle.
- PKT:
  - s_ready[grant] = (!m_valid || m_ready).
  - All other s_ready are 0.
  - A beat is accepted when s_valid[grant] && s_ready[grant]. It loads m_data/m_last and sets m_valid=1.
- Packet end: accepting a beat with s_last[grant]=1 returns the FSM to IDLE on the same edge. The output register may still hold that last beat.
- Output register: m_valid clears when m_ready=1 and no new beat is accepted. m_data/m_last hold while m_valid && !m_ready.
- `sel` changes during PKT are ignored. The lock holds until s_last.
- s_valid deassertion mid-packet: the block stays locked and waits (bubble). There is no timeout.
- Out-of-range sel (≥N) in MODE=0 is treated as not valid, so the block stays in IDLE.

## Timing
- Reset values:
  - state = IDLE
  - m_valid = 0, m_data = 0, m_last = 0
  - grant = 0
  - last_grant = N-1, so channel 0 wins first in MODE=1
  - busy = 0
  - s_ready = 0
- Reset mid-packet: in-flight beat and packet lock are discarded immediately (async). The consumer sees m_valid fall with reset.
- Latency: input beat accepted at edge k appears on m_data/m_valid after edge k (1 cycle).
- Throughput: 1 beat/cycle within a packet while m_ready=1.
- Packet overhead: 1 IDLE cycle between packets on the input side.
- Simultaneous last-beat accept and new valid on another channel: the new arbitration happens in the following IDLE cycle, not on the same edge.
- m_valid && !m_ready with a new beat pending: s_ready[grant]=0. There is no overwrite and no drop.
- Single-beat packet (s_last on first beat): IDLE → PKT → IDLE, 2 cycles per packet.

## Structure
- Shared package `axis_mux_pkg`:
  - constants MODE_SEL=0, MODE_RR=1
  - state enum {IDLE, PKT}
- Sub-module `axis_out_reg`: a one-stage data/last/valid register with ready back-pressure, parametrised by DATA_W. The top contains the FSM, the arbiter and the N:1 data selection.

## Test plan
- MODE=0, N=4, sel=2. Ch2 sends 3-beat packet 0xA1,0xA2,0xA3(last) with m_ready=1 → m_data shows A1,A2,A3 on consecutive cycles; m_last only on A3; s_ready[0,1,3] stay 0.
- MODE=0, sel switches 2→0 after beat 1 of a 4-beat ch2 packet → all 4 ch2 beats output. Ch0 is granted only after ch2's last beat, plus one IDLE cycle.
- MODE=1, all 4 channels continuously valid, each sending 2-beat packets → grant sequence 0,1,2,3,0. Each packet is contiguous on m_data.
- Back-pressure: m_ready toggles 1,0,0,1,1 during a 5-beat packet → no beat lost or duplicated; m_data stable while m_valid && !m_ready.
- Reset asserted mid-packet (beat 2 of 4) → m_valid, busy, s_ready go 0 immediately. After release, MODE=1 grants ch0 first.
- MODE=1, only ch3 valid with single-beat packets 0x11,0x22 → outputs 0x11 then 0x22, each preceded by an IDLE cycle; grant stays 3.
